// File: rtl/cap_prop_pkg.sv
// Shared types, constants and the corner-case operand table for the capability
// property stimulus driver.
package cap_prop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CORNER,
    RANDOM,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned CORNER_COUNT = 16;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Entry [k] is XORed with SEED to form the seed of LFSR k.
  localparam logic [4:0][31:0] SEED_XOR = {
    32'hC2B2AE35, 32'h85EBCA6B, 32'h7F4A7C15, 32'h9E3779B9, 32'h00000000
  };

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] len;
    logic [31:0] addr;
  } corner_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
    logic [31:0] base;
    logic [31:0] len;
    logic [31:0] addr;
  } chk_t;

  function automatic corner_t corner_entry(input logic [3:0] idx);
    corner_t e;
    case (idx)
      4'd0:    e = '{32'h00000000, 32'h00000000, 32'h00000000};
      4'd1:    e = '{32'h00000000, 32'h00000001, 32'h00000000};
      4'd2:    e = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
      4'd3:    e = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
      4'd4:    e = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      4'd5:    e = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
      4'd6:    e = '{32'h00001000, 32'h00001000, 32'h00001FFF};
      4'd7:    e = '{32'h00001000, 32'h00001000, 32'h00002000};
      4'd8:    e = '{32'h00000FFF, 32'h00001001, 32'h00001000};
      4'd9:    e = '{32'h7FFFF000, 32'h00002000, 32'h80000FFF};
      4'd10:   e = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
      4'd11:   e = '{32'h00FFFFF8, 32'h00000010, 32'h01000000};
      4'd12:   e = '{32'h12345678, 32'h00000000, 32'h12345678};
      4'd13:   e = '{32'h00000000, 32'h00002000, 32'h00001000};
      4'd14:   e = '{32'hFFFFE000, 32'h00002000, 32'hFFFFFFFF};
      default: e = '{32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF};
    endcase
    return e;
  endfunction

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/cap_prop_lfsr32.sv
// 32-bit Galois LFSR; reloads from seed on reset or load (a zero seed becomes 1).
module cap_prop_lfsr32
  import cap_prop_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] value_q;
  logic [31:0] value_d;
  logic [31:0] seed_nz;

  assign seed_nz = (seed == '0) ? 32'h00000001 : seed;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_nz;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_q <= seed_nz;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/cap_prop_stim_driver.sv
// Operand sequencer and scoreboard for the capability property checkers: corner
// table then LFSR vectors, ok_vec scored CHK_LAT cycles after issue.
module cap_prop_stim_driver
  import cap_prop_pkg::*;
#(
  parameter int unsigned          NUM_PROPS    = 8,
  parameter logic [NUM_PROPS-1:0] PROP_EN      = '1,
  parameter int unsigned          CHK_LAT      = 0,
  parameter logic [31:0]          NUM_VECTORS  = 32'd4096,
  parameter logic [31:0]          SEED         = 32'hACE12468,
  parameter bit                   STOP_ON_FAIL = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 op_valid,
  output logic [31:0]          op_base,
  output logic [31:0]          op_len,
  output logic [31:0]          op_addr,
  output logic [31:0]          op_newBase,
  output logic [31:0]          op_newLen,
  output logic [128:0]         op_in,
  input  logic [NUM_PROPS-1:0] ok_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          check_count,
  output logic [NUM_PROPS-1:0] fail_mask,
  output logic [31:0]          fail_index,
  output logic [31:0]          fail_base,
  output logic [31:0]          fail_len,
  output logic [31:0]          fail_addr
);

  localparam logic [32:0] LAST_IDX = {1'b0, NUM_VECTORS} + 33'(CORNER_COUNT - 1);

  state_e state_q, state_d;

  logic [31:0]          issue_idx_q;
  logic                 op_valid_q;
  logic [31:0]          op_idx_q;
  logic [31:0]          op_base_q, op_len_q, op_addr_q, op_newBase_q, op_newLen_q;
  logic [128:0]         op_in_q;
  logic [31:0]          check_count_q;
  logic [NUM_PROPS-1:0] fail_mask_q;
  logic [31:0]          fail_index_q, fail_base_q, fail_len_q, fail_addr_q;

  logic [31:0]          lfsr_val [5];
  corner_t              ce;
  chk_t                 tail;
  logic                 pipe_busy;
  logic [NUM_PROPS-1:0] fail_vec;
  logic                 first_fail;
  logic                 halt;
  logic                 start_run;
  logic                 issue_corner;
  logic                 issue_random;

  assign start_run  = start && ((state_q == IDLE) || (state_q == DONE));
  assign ce         = corner_entry(issue_idx_q[3:0]);
  assign fail_vec   = tail.valid ? (~ok_vec & PROP_EN) : '0;
  assign first_fail = (fail_mask_q == '0) && (fail_vec != '0);
  assign halt       = STOP_ON_FAIL && first_fail;

  for (genvar g = 0; g < 5; g++) begin : g_lfsr
    cap_prop_lfsr32 u_lfsr (
      .CLK   (CLK),
      .RST   (RST),
      .load  (start_run),
      .seed  (SEED ^ SEED_XOR[g]),
      .step  (issue_random),
      .value (lfsr_val[g])
    );
  end

  // The tail of the latency pipe is the set whose ok_vec is presented this cycle.
  if (CHK_LAT == 0) begin : g_comb
    assign tail      = {op_valid_q, op_idx_q, op_base_q, op_len_q, op_addr_q};
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    chk_t pipe_q [CHK_LAT];

    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int unsigned i = 0; i < CHK_LAT; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= {op_valid_q, op_idx_q, op_base_q, op_len_q, op_addr_q};
        for (int unsigned i = 1; i < CHK_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    always_comb begin
      pipe_busy = 1'b0;
      for (int unsigned i = 0; i < CHK_LAT; i++) begin
        pipe_busy = pipe_busy | pipe_q[i].valid;
      end
    end

    assign tail = pipe_q[CHK_LAT-1];
  end

  always_comb begin
    state_d      = state_q;
    issue_corner = 1'b0;
    issue_random = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = CORNER;
      end
      CORNER: begin
        if (halt) begin
          state_d = DRAIN;
        end else begin
          issue_corner = 1'b1;
          if (issue_idx_q == 32'(CORNER_COUNT - 1)) begin
            state_d = (NUM_VECTORS == '0) ? DRAIN : RANDOM;
          end
        end
      end
      RANDOM: begin
        if (halt) begin
          state_d = DRAIN;
        end else begin
          issue_random = 1'b1;
          if ({1'b0, issue_idx_q} == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!op_valid_q && !pipe_busy) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_idx_q   <= '0;
      op_valid_q    <= 1'b0;
      op_idx_q      <= '0;
      op_base_q     <= '0;
      op_len_q      <= '0;
      op_addr_q     <= '0;
      op_newBase_q  <= '0;
      op_newLen_q   <= '0;
      op_in_q       <= '0;
      check_count_q <= '0;
      fail_mask_q   <= '0;
      fail_index_q  <= '0;
      fail_base_q   <= '0;
      fail_len_q    <= '0;
      fail_addr_q   <= '0;
    end else begin
      op_valid_q <= issue_corner | issue_random;
      if (issue_corner) begin
        op_idx_q     <= issue_idx_q;
        op_base_q    <= ce.base;
        op_len_q     <= ce.len;
        op_addr_q    <= ce.addr;
        op_newBase_q <= ce.base ^ 32'h00001000;
        op_newLen_q  <= ce.len;
        op_in_q      <= {1'b1, 32'h0, ce.base, ce.len, ce.addr};
        issue_idx_q  <= issue_idx_q + 32'd1;
      end else if (issue_random) begin
        op_idx_q     <= issue_idx_q;
        op_base_q    <= lfsr_val[0];
        op_len_q     <= lfsr_val[1];
        op_addr_q    <= lfsr_val[2];
        op_newBase_q <= lfsr_val[3];
        op_newLen_q  <= lfsr_val[4];
        op_in_q      <= {lfsr_val[4][0], lfsr_val[4], lfsr_val[0], lfsr_val[1], lfsr_val[2]};
        issue_idx_q  <= issue_idx_q + 32'd1;
      end

      if (start_run) begin
        issue_idx_q   <= '0;
        check_count_q <= '0;
        fail_mask_q   <= '0;
        fail_index_q  <= '0;
        fail_base_q   <= '0;
        fail_len_q    <= '0;
        fail_addr_q   <= '0;
      end else if (tail.valid) begin
        if (check_count_q != '1) check_count_q <= check_count_q + 32'd1;
        // Only the first failing set is recorded; later ones just widen the mask.
        if (first_fail) begin
          fail_index_q <= tail.idx;
          fail_base_q  <= tail.base;
          fail_len_q   <= tail.len;
          fail_addr_q  <= tail.addr;
        end
        fail_mask_q <= fail_mask_q | fail_vec;
      end
    end
  end

  assign op_valid    = op_valid_q;
  assign op_base     = op_base_q;
  assign op_len      = op_len_q;
  assign op_addr     = op_addr_q;
  assign op_newBase  = op_newBase_q;
  assign op_newLen   = op_newLen_q;
  assign op_in       = op_in_q;
  assign busy        = (state_q == CORNER) || (state_q == RANDOM) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign pass        = done && (fail_mask_q == '0);
  assign check_count = check_count_q;
  assign fail_mask   = fail_mask_q;
  assign fail_index  = fail_index_q;
  assign fail_base   = fail_base_q;
  assign fail_len    = fail_len_q;
  assign fail_addr   = fail_addr_q;

endmodule

// File: tb/tb_cap_prop_stim_driver.sv
// Scoreboard bench: expected operand sets and run results come from a reference model.
module tb_cap_prop_stim_driver;

  localparam int          LAT  = 2;
  localparam int          NV   = 40;
  localparam int          T    = 16 + NV;
  localparam logic [7:0]  PEN  = 8'hF7;
  localparam bit          STOP = 1'b1;
  localparam logic [31:0] SEED = 32'hACE12468;

  localparam logic [31:0] SX [5] = '{32'h0, 32'h9E3779B9, 32'h7F4A7C15, 32'h85EBCA6B, 32'hC2B2AE35};
  localparam logic [31:0] CB [16] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
    32'h1000, 32'h1000, 32'hFFF, 32'h7FFFF000, 32'h1, 32'h00FFFFF8, 32'h12345678, 32'h0,
    32'hFFFFE000, 32'h55555555};
  localparam logic [31:0] CL [16] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000,
    32'h1000, 32'h1000, 32'h1001, 32'h2000, 32'hFFFFFFFE, 32'h10, 32'h0, 32'h2000, 32'h2000,
    32'hAAAAAAAA};
  localparam logic [31:0] CA [16] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF,
    32'h1FFF, 32'h2000, 32'h1000, 32'h80000FFF, 32'hFFFFFFFF, 32'h01000000, 32'h12345678,
    32'h1000, 32'hFFFFFFFF, 32'hFFFFFFFF};

  typedef struct packed {
    logic [31:0]  base;
    logic [31:0]  len;
    logic [31:0]  addr;
    logic [31:0]  nb;
    logic [31:0]  nl;
    logic [128:0] in;
  } op_t;

  logic         CLK, RST, start;
  logic         op_valid;
  logic [31:0]  op_base, op_len, op_addr, op_newBase, op_newLen;
  logic [128:0] op_in;
  logic [7:0]   ok_vec;
  logic         busy, done, pass;
  logic [31:0]  check_count, fail_index, fail_base, fail_len, fail_addr;
  logic [7:0]   fail_mask;

  cap_prop_stim_driver #(
    .NUM_PROPS    (8),
    .PROP_EN      (PEN),
    .CHK_LAT      (LAT),
    .NUM_VECTORS  (32'(NV)),
    .SEED         (SEED),
    .STOP_ON_FAIL (STOP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .op_valid    (op_valid),
    .op_base     (op_base),
    .op_len      (op_len),
    .op_addr     (op_addr),
    .op_newBase  (op_newBase),
    .op_newLen   (op_newLen),
    .op_in       (op_in),
    .ok_vec      (ok_vec),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .check_count (check_count),
    .fail_mask   (fail_mask),
    .fail_index  (fail_index),
    .fail_base   (fail_base),
    .fail_len    (fail_len),
    .fail_addr   (fail_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         checks, errors;
  logic [7:0] fault_bits [64];
  op_t        exp_arr [64];
  int         wr_ptr, rd_ptr, cnt;
  int         hist [LAT+1];
  logic       restart_req;
  logic       exp_pass;
  int         exp_count;
  logic [7:0] exp_mask;
  logic [31:0] exp_idx, exp_fb, exp_fl, exp_fa;

  task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [7:0] fault_at(input int i);
    if (i < 0 || i >= 64) return 8'h00;
    return fault_bits[i];
  endfunction

  // Reference model: the full operand sequence and the run outcome for fault_bits.
  task automatic prepare_run();
    logic [31:0] l [5];
    int ff, n;
    for (int k = 0; k < 5; k++) begin
      l[k] = SEED ^ SX[k];
      if (l[k] == 32'h0) l[k] = 32'h1;
    end
    for (int i = 0; i < T; i++) begin
      if (i < 16) begin
        exp_arr[i] = '{CB[i], CL[i], CA[i], CB[i] ^ 32'h1000, CL[i], {1'b1, 32'h0, CB[i], CL[i], CA[i]}};
      end else begin
        exp_arr[i] = '{l[0], l[1], l[2], l[3], l[4], {l[4][0], l[4], l[0], l[1], l[2]}};
        for (int k = 0; k < 5; k++) l[k] = lfsr_step(l[k]);
      end
    end
    ff = -1;
    for (int i = 0; i < T; i++) if (ff < 0 && (fault_bits[i] & PEN) != 8'h0) ff = i;
    n = T;
    if (STOP && ff >= 0 && ff + LAT + 1 < T) n = ff + LAT + 1;
    exp_mask = 8'h0;
    for (int i = 0; i < n; i++) exp_mask |= fault_bits[i] & PEN;
    exp_count = n;
    exp_pass  = (exp_mask == 8'h0);
    exp_idx   = (ff >= 0) ? 32'(ff) : 32'h0;
    exp_fb    = (ff >= 0) ? exp_arr[ff].base : 32'h0;
    exp_fl    = (ff >= 0) ? exp_arr[ff].len : 32'h0;
    exp_fa    = (ff >= 0) ? exp_arr[ff].addr : 32'h0;
    wr_ptr    = n;
  endtask

  task automatic pulse_start(input logic real_start);
    @(posedge CLK); #1;
    start = 1'b1;
    restart_req = real_start;
    @(posedge CLK); #1;
    start = 1'b0;
    restart_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 500 && !done; c++) begin
      @(posedge CLK); #1;
    end
    chk({nm, "_done"}, 320'(done), 320'(1));
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic wait_cnt(input int target);
    for (int c = 0; c < 300 && cnt < target; c++) begin
      @(posedge CLK); #1;
    end
    chk("cnt_reach", 320'(cnt >= target), 320'(1));
  endtask

  task automatic end_checks(input string nm);
    chk({nm, "_status"}, 320'({busy, done, pass}), 320'({1'b0, 1'b1, exp_pass}));
    chk({nm, "_count"}, 320'(check_count), 320'(exp_count));
    chk({nm, "_mask"}, 320'(fail_mask), 320'(exp_mask));
    chk({nm, "_index"}, 320'(fail_index), 320'(exp_idx));
    chk({nm, "_fops"}, 320'({fail_base, fail_len, fail_addr}), 320'({exp_fb, exp_fl, exp_fa}));
    chk({nm, "_issued"}, 320'(rd_ptr), 320'(wr_ptr));
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_ctrl"}, 320'({op_valid, busy, done, pass, fail_mask}), 320'(0));
    chk({nm, "_cnt"}, 320'({check_count, fail_index}), 320'(0));
    chk({nm, "_fops"}, 320'({fail_base, fail_len, fail_addr}), 320'(0));
    chk({nm, "_ops"}, 320'({op_base, op_len, op_addr, op_newBase, op_newLen}), 320'(0));
    chk({nm, "_opin"}, 320'(op_in), 320'(0));
  endtask

  task automatic run_plain(input string nm);
    prepare_run();
    pulse_start(1'b1);
    wait_done(nm);
    end_checks(nm);
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_ptr = 0; rd_ptr = 0; cnt = 0;
    restart_req = 1'b0; start = 1'b0; RST = 1'b1; ok_vec = 8'hFF;
    for (int i = 0; i < 64; i++) fault_bits[i] = 8'h0;
    for (int k = 0; k <= LAT; k++) hist[k] = -1;
    fork
      begin : monitor
        forever begin
          int cur;
          @(negedge CLK);
          if (restart_req) begin
            rd_ptr = 0;
            cnt = 0;
            for (int k = 0; k <= LAT; k++) hist[k] = -1;
          end
          cur = -1;
          if (op_valid) begin
            if (rd_ptr >= wr_ptr) begin
              chk("op_extra", 320'(rd_ptr), 320'(wr_ptr - 1));
            end else begin
              op_t got;
              got = '{op_base, op_len, op_addr, op_newBase, op_newLen, op_in};
              chk($sformatf("op_%0d", cnt), 320'(got), 320'(exp_arr[rd_ptr]));
            end
            rd_ptr++;
            cur = cnt;
            cnt++;
          end
          for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = cur;
          if (hist[LAT] < 0) begin
            ok_vec = 8'($urandom);
          end else begin
            ok_vec = ~fault_at(hist[LAT]);
            ok_vec[3] = 1'($urandom);
          end
        end
      end
      begin : driver
        repeat (3) @(posedge CLK);
        #1;
        reset_checks("rst");
        RST = 1'b0;

        // Clean run with a start pulse while busy that must be ignored.
        prepare_run();
        pulse_start(1'b1);
        wait_cnt(8);
        pulse_start(1'b0);
        chk("busy_start_ignored", 320'({busy, done}), 320'({1'b1, 1'b0}));
        wait_done("clean");
        end_checks("clean");

        // Disabled property only.
        fault_bits[5] = 8'h08; fault_bits[30] = 8'h08;
        run_plain("masked");

        // Two random-region faults; second lands in flight after the stop.
        for (int i = 0; i < 64; i++) fault_bits[i] = 8'h0;
        fault_bits[20] = 8'h01; fault_bits[21] = 8'h02; fault_bits[40] = 8'h04;
        run_plain("rand_fault");

        // Corner fault on entry 5.
        for (int i = 0; i < 64; i++) fault_bits[i] = 8'h0;
        fault_bits[5] = 8'h04;
        run_plain("corner5");
        chk("corner5_const", 320'({fail_index, fail_base, fail_addr, fail_mask}),
            320'({32'd5, 32'h80000000, 32'h7FFFFFFF, 8'h04}));

        // start in DONE clears the results on the CORNER entry edge.
        for (int i = 0; i < 64; i++) fault_bits[i] = 8'h0;
        prepare_run();
        pulse_start(1'b1);
        chk("restart_clear", 320'({busy, done, pass, check_count, fail_mask, fail_index}),
            320'({1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 32'd0}));
        wait_done("rerun");
        end_checks("rerun");

        // Reset a few sets into RANDOM, then restart from index 0.
        prepare_run();
        pulse_start(1'b1);
        wait_cnt(19);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        reset_checks("midrst");
        RST = 1'b0;
        run_plain("after_rst");

        for (int r = 0; r < 5; r++) begin
          int nf;
          for (int i = 0; i < 64; i++) fault_bits[i] = 8'h0;
          nf = int'($urandom_range(0, 2));
          for (int f = 0; f < nf; f++) begin
            int idx;
            idx = int'($urandom_range(0, T - 1));
            fault_bits[idx] = fault_bits[idx] | (8'h01 << $urandom_range(0, 7));
          end
          run_plain($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
